// File: rtl/spi_pkg.sv
// Shared definitions for the SPI bring-up master: default frame geometry
// and the shift-engine state encoding.
package spi_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_CLK_DIV = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

endpackage

// File: rtl/spi_master_core.sv
// Reusable SPI mode-0 shift engine, MSB first. One frame per accepted start;
// done pulses combinationally during the last clock of the frame so the
// owner can update its registers on the same edge that releases cs.
module spi_master_core
    import spi_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic              miso,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
    output logic              mosi,
    output logic              sclk,
    output logic              cs
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    spi_state_t        state;
    spi_state_t        state_nxt;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bitcnt;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic              tick;
    logic              load;
    logic              rise;
    logic              fall;

    // End of the current SCLK half-period.
    assign tick     = (cnt == CNT_LAST);
    assign data_out = rx_sr;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; XFER covers 15 half-periods, HOLD is the final low one.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = SETUP;
            SETUP: if (tick) state_nxt = XFER;
            XFER:  if (tick && sclk && (bitcnt == BIT_LAST)) state_nxt = HOLD;
            HOLD:  if (tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: per-clock strobes for the datapath.
    always_comb begin
        load = 1'b0;
        rise = 1'b0;
        fall = 1'b0;
        done = 1'b0;
        case (state)
            IDLE:  load = start;
            SETUP: rise = tick;
            XFER: begin
                rise = tick && !sclk;
                fall = tick && sclk;
            end
            HOLD:  done = tick;
            default: ;
        endcase
    end

    // Half-period divider; held at zero while idle so every frame starts aligned.
    always_ff @(posedge clk) begin
        if (!rst || (state == IDLE) || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Serial datapath: cs/sclk/mosi are registered so they are glitch-free.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cs     <= 1'b1;
            sclk   <= 1'b0;
            mosi   <= 1'b0;
            bitcnt <= '0;
            tx_sr  <= '0;
            rx_sr  <= '0;
        end else begin
            if (load) begin
                cs     <= 1'b0;
                tx_sr  <= data_in;
                mosi   <= data_in[DATA_W-1];
                bitcnt <= '0;
            end
            if (rise) begin
                sclk  <= 1'b1;
                rx_sr <= {rx_sr[DATA_W-2:0], miso};
            end
            if (fall) begin
                sclk   <= 1'b0;
                bitcnt <= bitcnt + 1'b1;
                // The last falling edge leaves the final bit on the line.
                if (bitcnt != BIT_LAST) begin
                    tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                    mosi  <= tx_sr[DATA_W-2];
                end
            end
            if (done) begin
                cs   <= 1'b1;
                mosi <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/spi_master_top.sv
// Board bring-up SPI master: sends an incrementing byte pattern and keeps
// the last received byte internally for inspection.
module spi_master_top
    import spi_pkg::*;
#(
    parameter int              DATA_W  = DEF_DATA_W,
    parameter int              CLK_DIV = DEF_CLK_DIV,
    parameter logic [DATA_W-1:0] TX_INIT = 8'hA5
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic miso,
    output logic mosi,
    output logic sclk,
    output logic cs
);

    logic [DATA_W-1:0] tx_data;
    logic [DATA_W-1:0] rx_data;
    logic [DATA_W-1:0] core_rx;
    logic              core_done;

    spi_master_core #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (tx_data),
        .miso     (miso),
        .data_out (core_rx),
        .done     (core_done),
        .mosi     (mosi),
        .sclk     (sclk),
        .cs       (cs)
    );

    // Frame bookkeeping: capture the received byte and advance the pattern
    // only when a frame completes, so an aborted frame leaves both untouched.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_data <= TX_INIT;
            rx_data <= '0;
        end else if (core_done) begin
            tx_data <= tx_data + 1'b1;
            rx_data <= core_rx;
        end
    end

endmodule

// File: tb/tb_spi_master_top.sv
// Directed bench for spi_master_top: a bus monitor rebuilds each frame from
// the pins (byte on rising sclk, cs-low length, pulse count, cs-high gap)
// and a small slave model can shift a byte back on miso.
module tb_spi_master_top;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic miso_drv = 1'b0;
    logic use_slave = 1'b0;
    logic miso;
    logic mosi;
    logic sclk;
    logic cs;

    int errors = 0;
    int checks = 0;

    logic [7:0] sl_sr = 8'h00;
    logic [7:0] cur_byte = 8'h00;
    int cur_low = 0;
    int cur_pulses = 0;
    int cur_gap = 0;
    bit seen = 1'b0;
    logic prev_sclk = 1'b0;
    logic prev_cs = 1'b1;
    logic [7:0] byte_q[$];
    int low_q[$];
    int pulse_q[$];
    int gap_q[$];

    assign miso = use_slave ? sl_sr[7] : miso_drv;

    always #5 clk = ~clk;

    spi_master_top dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .miso  (miso),
        .mosi  (mosi),
        .sclk  (sclk),
        .cs    (cs)
    );

    // Pin monitor and slave model, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            byte_q.delete(); low_q.delete(); pulse_q.delete(); gap_q.delete();
            cur_byte <= 8'h00; cur_low <= 0; cur_pulses <= 0; cur_gap <= 0;
            seen <= 1'b0; prev_sclk <= 1'b0; prev_cs <= 1'b1;
        end else begin
            if (sclk && !prev_sclk) begin
                cur_byte <= {cur_byte[6:0], mosi};
                cur_pulses <= cur_pulses + 1;
            end
            if (!sclk && prev_sclk) sl_sr <= {sl_sr[6:0], 1'b0};
            if (!cs) begin
                if (prev_cs) begin
                    if (seen) gap_q.push_back(cur_gap);
                    sl_sr <= 8'h3C;
                    cur_low <= 1;
                end else begin
                    cur_low <= cur_low + 1;
                end
            end else begin
                if (!prev_cs) begin
                    byte_q.push_back(cur_byte);
                    low_q.push_back(cur_low);
                    pulse_q.push_back(cur_pulses);
                    seen <= 1'b1;
                    cur_pulses <= 0;
                    cur_gap <= 1;
                end else begin
                    cur_gap <= cur_gap + 1;
                end
            end
            prev_sclk <= sclk;
            prev_cs <= cs;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while ((byte_q.size() < n) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        check_eq("frame_count", 32'(byte_q.size()), 32'(n));
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic check_frame(input string tag, input int idx, input logic [7:0] exp_byte);
        if (byte_q.size() > idx) begin
            check_eq({tag, "_byte"}, 32'(byte_q[idx]), 32'(exp_byte));
            check_eq({tag, "_cslow"}, 32'(low_q[idx]), 32'd68);
            check_eq({tag, "_pulses"}, 32'(pulse_q[idx]), 32'd8);
        end else begin
            check_eq({tag, "_present"}, 32'(byte_q.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        int n0;
        int k;

        // Reset state
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_cs", 32'(cs), 32'd1);
        check_eq("rst_sclk", 32'(sclk), 32'd0);
        check_eq("rst_mosi", 32'(mosi), 32'd0);
        check_eq("rst_tx", 32'(dut.tx_data), 32'hA5);
        check_eq("rst_rx", 32'(dut.rx_data), 32'h00);
        #1 rst = 1'b1;

        // Single frame, miso held high
        miso_drv = 1'b1;
        n0 = byte_q.size();
        pulse_start();
        wait_frames(n0 + 1, 300);
        check_frame("single", n0, 8'hA5);
        check_eq("single_rx", 32'(dut.rx_data), 32'hFF);
        check_eq("single_tx", 32'(dut.tx_data), 32'hA6);

        // Receive pattern from slave model
        use_slave = 1'b1;
        n0 = byte_q.size();
        pulse_start();
        wait_frames(n0 + 1, 300);
        check_frame("recv", n0, 8'hA6);
        check_eq("recv_rx", 32'(dut.rx_data), 32'h3C);
        check_eq("recv_tx", 32'(dut.tx_data), 32'hA7);
        use_slave = 1'b0;
        miso_drv = 1'b0;

        // Continuous start from reset
        do_reset();
        @(posedge clk); #1 start = 1'b1;
        wait_frames(2, 400);
        k = 0;
        while (cs && (k < 50)) begin
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        wait_frames(3, 300);
        repeat (150) @(negedge clk);
        check_eq("cont_nframes", 32'(byte_q.size()), 32'd3);
        check_frame("cont0", 0, 8'hA5);
        check_frame("cont1", 1, 8'hA6);
        check_frame("cont2", 2, 8'hA7);
        check_eq("cont_ngaps", 32'(gap_q.size()), 32'd2);
        if (gap_q.size() >= 2) begin
            check_eq("cont_gap0", 32'(gap_q[0]), 32'd1);
            check_eq("cont_gap1", 32'(gap_q[1]), 32'd1);
        end

        // Busy: start pulse mid-frame is ignored
        n0 = byte_q.size();
        pulse_start();
        repeat (30) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_frames(n0 + 1, 300);
        repeat (200) @(negedge clk);
        check_eq("busy_nframes", 32'(byte_q.size()), 32'(n0 + 1));
        check_frame("busy", n0, 8'hA8);
        check_eq("busy_tx", 32'(dut.tx_data), 32'hA9);

        // Abort at bit 4
        pulse_start();
        k = 0;
        while ((cur_pulses < 4) && (k < 200)) begin
            @(negedge clk);
            k++;
        end
        check_eq("abort_reached_bit4", 32'(cur_pulses), 32'd4);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_cs", 32'(cs), 32'd1);
        check_eq("abort_sclk", 32'(sclk), 32'd0);
        check_eq("abort_mosi", 32'(mosi), 32'd0);
        #1 rst = 1'b1;
        repeat (100) @(negedge clk);
        check_eq("abort_cs_idle", 32'(cs), 32'd1);
        check_eq("abort_tx", 32'(dut.tx_data), 32'hA5);
        check_eq("abort_rx", 32'(dut.rx_data), 32'h00);

        // Wrap: run frames until tx_data reaches FF, then one more frame
        @(posedge clk); #1 start = 1'b1;
        k = 0;
        while ((dut.tx_data != 8'hFF) && (k < 10000)) begin
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check_eq("wrap_reach_ff", 32'(dut.tx_data), 32'hFF);
        repeat (10) @(negedge clk);
        n0 = byte_q.size();
        pulse_start();
        wait_frames(n0 + 1, 300);
        check_frame("wrap", n0, 8'hFF);
        check_eq("wrap_tx", 32'(dut.tx_data), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
